// File: rtl/sprite_compositor_pkg.sv
// Shared constants and helpers for the sprite compositor: default code
// format, sprite index map and a lowest-set-bit search.
package sprite_pkg;

    localparam int CODE_W_DEF      = 4;
    localparam int TRANSPARENT_DEF = 0;

    localparam int CUE_BALL      = 16;
    localparam int CUE_STICK_0   = 17;
    localparam int CUE_STICK_45  = 18;
    localparam int CUE_STICK_90  = 19;
    localparam int CUE_STICK_135 = 20;
    localparam int CUE_STICK_180 = 21;
    localparam int CUE_STICK_225 = 22;
    localparam int CUE_STICK_270 = 23;
    localparam int CUE_STICK_315 = 24;

    localparam int MAX_VEC_W = 64;

    // Scanning from the top down leaves the lowest set index in r; 0 if none set.
    function automatic int lowest_set(input logic [MAX_VEC_W-1:0] v);
        int r;
        r = 0;
        for (int i = MAX_VEC_W - 1; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Per-pixel bus between the sprite/background sources and the compositor,
// plus the composited code and per-frame collision results.
interface sprite_compositor_if
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 24,
    parameter int NUM_BALLS   = 16,
    parameter int CODE_W      = CODE_W_DEF,
    parameter int CNT_W       = 16
);
    localparam int SEL_W = $clog2(NUM_SPRITES + 1);

    logic                          pix_valid_i;
    logic                          frame_start_i;
    logic [SEL_W-1:0]              select_i;
    logic                          prio_mode_i;
    logic [NUM_SPRITES*CODE_W-1:0] codes_i;
    logic [CODE_W-1:0]             bg_code_i;
    logic [CODE_W-1:0]             code_o;
    logic                          valid_o;
    logic [NUM_BALLS-1:0]          collision_o;
    logic [CNT_W-1:0]              overlap_cnt_o;

    modport master (
        output pix_valid_i, frame_start_i, select_i, prio_mode_i, codes_i, bg_code_i,
        input  code_o, valid_o, collision_o, overlap_cnt_o
    );

    modport slave (
        input  pix_valid_i, frame_start_i, select_i, prio_mode_i, codes_i, bg_code_i,
        output code_o, valid_o, collision_o, overlap_cnt_o
    );

endinterface

// File: rtl/sprite_compositor_prio_enc.sv
// First-set priority encoder: index of the lowest set bit plus a found flag.
module sprite_prio_enc
    import sprite_pkg::*;
#(
    parameter int W     = 16,
    parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    assign found = |vec;
    assign idx   = IDX_W'(lowest_set(MAX_VEC_W'(vec)));

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage per-pixel sprite priority compositor with per-frame ball
// overlap detection (collision vector and overlap-pixel count).
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int                NUM_SPRITES = 24,
    parameter int                NUM_BALLS   = 16,
    parameter int                CODE_W      = CODE_W_DEF,
    parameter logic [CODE_W-1:0] TRANSPARENT = CODE_W'(TRANSPARENT_DEF),
    parameter int                CNT_W       = 16
) (
    input logic                Clk,
    input logic                Reset_n,
    sprite_compositor_if.slave bus
);

    localparam int SEL_W  = $clog2(NUM_SPRITES + 1);
    localparam int SIDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int BIDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;

    logic                          s1_valid;
    logic                          s1_prio;
    logic [SEL_W-1:0]              s1_select;
    logic [NUM_SPRITES*CODE_W-1:0] s1_codes;
    logic [CODE_W-1:0]             s1_bg;
    logic [NUM_SPRITES-1:0]        s1_opaque;

    logic [NUM_SPRITES-1:0] in_opaque;
    logic [SEL_W-1:0]       in_select;

    always_comb begin
        for (int k = 0; k < NUM_SPRITES; k++) begin
            in_opaque[k] = (bus.codes_i[k*CODE_W +: CODE_W] != TRANSPARENT);
        end
        in_select = (bus.select_i > SEL_W'(NUM_SPRITES)) ? '0 : bus.select_i;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid  <= 1'b0;
            s1_prio   <= 1'b0;
            s1_select <= '0;
            s1_codes  <= '0;
            s1_bg     <= '0;
            s1_opaque <= '0;
        end else begin
            s1_valid  <= bus.pix_valid_i;
            s1_prio   <= bus.prio_mode_i;
            s1_select <= in_select;
            s1_codes  <= bus.codes_i;
            s1_bg     <= bus.bg_code_i;
            s1_opaque <= in_opaque;
        end
    end

    logic [NUM_SPRITES-1:0] sel_mask;
    logic                   sel_hit;
    logic [CODE_W-1:0]      sel_code;

    always_comb begin
        sel_code = '0;
        for (int k = 0; k < NUM_SPRITES; k++) begin
            sel_mask[k] = (s1_select == SEL_W'(k + 1));
            if (sel_mask[k]) sel_code = s1_codes[k*CODE_W +: CODE_W];
        end
        sel_hit = |(sel_mask & s1_opaque);
    end

    // Collision term uses last frame's published vector, so feedback lags one frame.
    logic [NUM_BALLS-1:0] coll_vec;
    logic [BIDX_W-1:0]    coll_idx;
    logic                 coll_found;
    logic [SIDX_W-1:0]    z_idx;
    logic                 z_found;

    assign coll_vec = bus.collision_o & s1_opaque[NUM_BALLS-1:0] & ~sel_mask[NUM_BALLS-1:0];

    sprite_prio_enc #(.W(NUM_BALLS), .IDX_W(BIDX_W)) u_coll_enc (
        .vec   (coll_vec),
        .idx   (coll_idx),
        .found (coll_found)
    );

    sprite_prio_enc #(.W(NUM_SPRITES), .IDX_W(SIDX_W)) u_z_enc (
        .vec   (s1_opaque),
        .idx   (z_idx),
        .found (z_found)
    );

    logic [CODE_W-1:0] coll_code;
    logic [CODE_W-1:0] z_code;
    logic [CODE_W-1:0] next_code;

    always_comb begin
        coll_code = '0;
        z_code    = '0;
        for (int k = 0; k < NUM_BALLS; k++) begin
            if (coll_idx == BIDX_W'(k)) coll_code = s1_codes[k*CODE_W +: CODE_W];
        end
        for (int k = 0; k < NUM_SPRITES; k++) begin
            if (z_idx == SIDX_W'(k)) z_code = s1_codes[k*CODE_W +: CODE_W];
        end
        if (sel_hit)                 next_code = sel_code;
        else if (coll_found)         next_code = coll_code;
        else if (s1_prio && z_found) next_code = z_code;
        else                         next_code = s1_bg;
    end

    // v & (v - 1) is nonzero exactly when two or more balls are opaque.
    logic [NUM_BALLS-1:0] ball_opaque;
    logic                 overlap_hit;
    logic [NUM_BALLS-1:0] contrib;
    logic [NUM_BALLS-1:0] acc;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;

    always_comb begin
        ball_opaque = s1_opaque[NUM_BALLS-1:0];
        overlap_hit = s1_valid && (|(ball_opaque & (ball_opaque - 1'b1)));
        contrib     = overlap_hit ? ball_opaque : '0;
        cnt_next    = cnt;
        if (overlap_hit && (cnt != '1)) cnt_next = cnt + 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            acc               <= '0;
            cnt               <= '0;
            bus.collision_o   <= '0;
            bus.overlap_cnt_o <= '0;
        end else if (bus.frame_start_i) begin
            bus.collision_o   <= acc | contrib;
            bus.overlap_cnt_o <= cnt_next;
            acc               <= '0;
            cnt               <= '0;
        end else begin
            acc <= acc | contrib;
            cnt <= cnt_next;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.code_o  <= '0;
            bus.valid_o <= 1'b0;
        end else begin
            bus.code_o  <= next_code;
            bus.valid_o <= s1_valid;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: directed scenarios plus a
// randomized run against a pixel-level reference model.
module tb_sprite_compositor;

    localparam int NS = 24;
    localparam int NB = 16;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        pix_valid;
    logic        frame_start;
    logic        prio_mode;
    logic [4:0]  sel;
    logic [95:0] codes;
    logic [3:0]  bg;

    int tests = 0;
    int failed = 0;

    always #5 Clk = ~Clk;

    sprite_compositor_if #(.NUM_SPRITES(NS), .NUM_BALLS(NB), .CODE_W(4), .CNT_W(16)) bus ();
    sprite_compositor_if #(.NUM_SPRITES(NS), .NUM_BALLS(NB), .CODE_W(4), .CNT_W(2))  bus_s ();

    assign bus.pix_valid_i     = pix_valid;
    assign bus.frame_start_i   = frame_start;
    assign bus.select_i        = sel;
    assign bus.prio_mode_i     = prio_mode;
    assign bus.codes_i         = codes;
    assign bus.bg_code_i       = bg;
    assign bus_s.pix_valid_i   = pix_valid;
    assign bus_s.frame_start_i = frame_start;
    assign bus_s.select_i      = sel;
    assign bus_s.prio_mode_i   = prio_mode;
    assign bus_s.codes_i       = codes;
    assign bus_s.bg_code_i     = bg;

    sprite_compositor #(.NUM_SPRITES(NS), .NUM_BALLS(NB), .CODE_W(4), .TRANSPARENT(4'h0), .CNT_W(16)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    sprite_compositor #(.NUM_SPRITES(NS), .NUM_BALLS(NB), .CODE_W(4), .TRANSPARENT(4'h0), .CNT_W(2)) dut_s (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus_s)
    );

    // Reference model: the pixel currently held one cycle in, plus frame totals.
    logic        m1_valid;
    logic        m1_mode;
    int          m1_sel;
    logic [95:0] m1_codes;
    logic [3:0]  m1_bg;
    logic [3:0]  exp_code;
    logic        exp_valid;
    logic [15:0] exp_coll;
    logic [15:0] acc;
    int          cnt;
    int          pub;

    function automatic logic [3:0] code_of(input logic [95:0] c, input int k);
        return c[(k-1)*4 +: 4];
    endfunction

    function automatic logic [95:0] put(input logic [95:0] c, input int k, input logic [3:0] v);
        logic [95:0] r;
        r = c;
        r[(k-1)*4 +: 4] = v;
        return r;
    endfunction

    function automatic logic [3:0] compose();
        int s;
        s = (m1_sel > NS) ? 0 : m1_sel;
        if (s >= 1 && code_of(m1_codes, s) != 4'h0) return code_of(m1_codes, s);
        for (int b = 1; b <= NB; b++) begin
            if (exp_coll[b-1] && b != s && code_of(m1_codes, b) != 4'h0) return code_of(m1_codes, b);
        end
        if (m1_mode) begin
            for (int k = 1; k <= NS; k++) begin
                if (code_of(m1_codes, k) != 4'h0) return code_of(m1_codes, k);
            end
        end
        return m1_bg;
    endfunction

    task automatic model_reset();
        m1_valid  = 1'b0;
        m1_mode   = 1'b0;
        m1_sel    = 0;
        m1_codes  = '0;
        m1_bg     = '0;
        exp_code  = '0;
        exp_valid = 1'b0;
        exp_coll  = '0;
        acc       = '0;
        cnt       = 0;
        pub       = 0;
    endtask

    task automatic step(input logic v, input logic fs, input logic [4:0] s, input logic m,
                        input logic [95:0] c, input logic [3:0] b);
        logic [3:0]  nc;
        logic [15:0] balls;
        int          nb;
        logic        hit;
        pix_valid   = v;
        frame_start = fs;
        sel         = s;
        prio_mode   = m;
        codes       = c;
        bg          = b;
        @(posedge Clk);
        nc    = compose();
        balls = '0;
        nb    = 0;
        for (int k = 1; k <= NB; k++) begin
            if (code_of(m1_codes, k) != 4'h0) begin
                balls[k-1] = 1'b1;
                nb++;
            end
        end
        hit = m1_valid && (nb >= 2);
        if (frame_start) begin
            exp_coll = acc | (hit ? balls : 16'h0);
            pub      = cnt + (hit ? 1 : 0);
            acc      = '0;
            cnt      = 0;
        end else if (hit) begin
            acc = acc | balls;
            cnt = cnt + 1;
        end
        exp_code  = nc;
        exp_valid = m1_valid;
        m1_valid  = pix_valid;
        m1_mode   = prio_mode;
        m1_sel    = int'(sel);
        m1_codes  = codes;
        m1_bg     = bg;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 1'b0, '0, 4'h0);
    endtask

    task automatic test_reset();
        logic [95:0] c;
        for (int i = 0; i < 4; i++) begin
            c = '0;
            for (int k = 1; k <= NS; k++) c = put(c, k, 4'($urandom_range(1, 15)));
            step(1'b1, 1'b0, 5'($urandom_range(0, 24)), 1'b1, c, 4'($urandom_range(1, 15)));
        end
        #2;
        Reset_n = 1'b0;
        #1;
        tests++;
        if (bus.code_o !== 4'h0) begin
            failed++;
            $display("[TB] FAIL reset_code: got %h expected 0", bus.code_o);
        end
        tests++;
        if (bus.valid_o !== 1'b0 || bus_s.valid_o !== 1'b0) begin
            failed++;
            $display("[TB] FAIL reset_valid: got %b/%b expected 0", bus.valid_o, bus_s.valid_o);
        end
        tests++;
        if (bus.collision_o !== 16'h0 || bus.overlap_cnt_o !== 16'h0) begin
            failed++;
            $display("[TB] FAIL reset_collision: got %h/%h expected 0/0", bus.collision_o, bus.overlap_cnt_o);
        end
        model_reset();
        repeat (2) @(posedge Clk);
        #3;
        Reset_n = 1'b1;
        step(1'b1, 1'b0, 5'd0, 1'b0, '0, 4'hC);
        tests++;
        if (bus.valid_o !== 1'b0) begin
            failed++;
            $display("[TB] FAIL reset_latency1: got valid %b expected 0", bus.valid_o);
        end
        idle();
        tests++;
        if (bus.valid_o !== 1'b1 || bus.code_o !== 4'hC) begin
            failed++;
            $display("[TB] FAIL reset_latency2: got valid %b code %h expected 1 c", bus.valid_o, bus.code_o);
        end
    endtask

    task automatic test_select();
        logic [95:0] c;
        c = put('0, 5, 4'h7);
        step(1'b1, 1'b0, 5'd5, 1'b0, c, 4'h2);
        idle();
        tests++;
        if (bus.code_o !== 4'h7) begin
            failed++;
            $display("[TB] FAIL select_opaque: got %h expected 7", bus.code_o);
        end
        c = put(c, 5, 4'h0);
        step(1'b1, 1'b0, 5'd5, 1'b0, c, 4'h2);
        idle();
        tests++;
        if (bus.code_o !== 4'h2) begin
            failed++;
            $display("[TB] FAIL select_transparent: got %h expected 2", bus.code_o);
        end
    endtask

    task automatic test_overlap();
        logic [95:0] c;
        c = put(put('0, 3, 4'h9), 16, 4'hA);
        step(1'b0, 1'b1, 5'd0, 1'b0, '0, 4'h0);
        repeat (3) step(1'b1, 1'b0, 5'd0, 1'b0, c, 4'h2);
        step(1'b0, 1'b1, 5'd0, 1'b0, '0, 4'h0);
        tests++;
        if (bus.collision_o !== 16'h8004) begin
            failed++;
            $display("[TB] FAIL overlap_vector: got %h expected 8004", bus.collision_o);
        end
        tests++;
        if (bus.overlap_cnt_o !== 16'd3 || bus_s.overlap_cnt_o !== 2'd3) begin
            failed++;
            $display("[TB] FAIL overlap_count: got %0d/%0d expected 3/3", bus.overlap_cnt_o, bus_s.overlap_cnt_o);
        end
    endtask

    task automatic test_collision_priority();
        logic [95:0] c;
        c = put(put('0, 3, 4'h9), 16, 4'hA);
        step(1'b1, 1'b0, 5'd0, 1'b0, c, 4'h2);
        idle();
        tests++;
        if (bus.code_o !== 4'h9) begin
            failed++;
            $display("[TB] FAIL coll_lowest: got %h expected 9", bus.code_o);
        end
        step(1'b1, 1'b0, 5'd3, 1'b0, c, 4'h2);
        idle();
        tests++;
        if (bus.code_o !== 4'h9) begin
            failed++;
            $display("[TB] FAIL coll_select_same: got %h expected 9", bus.code_o);
        end
        step(1'b1, 1'b0, 5'd3, 1'b0, put('0, 16, 4'hA), 4'h2);
        idle();
        tests++;
        if (bus.code_o !== 4'hA) begin
            failed++;
            $display("[TB] FAIL coll_skip_select: got %h expected a", bus.code_o);
        end
        step(1'b1, 1'b0, 5'd0, 1'b0, put('0, 7, 4'h5), 4'h2);
        idle();
        tests++;
        if (bus.code_o !== 4'h2) begin
            failed++;
            $display("[TB] FAIL coll_not_flagged: got %h expected 2", bus.code_o);
        end
        step(1'b0, 1'b1, 5'd0, 1'b0, '0, 4'h0);
        tests++;
        if (bus.collision_o !== 16'h8004 || bus.overlap_cnt_o !== 16'd2) begin
            failed++;
            $display("[TB] FAIL coll_frame2: got %h/%0d expected 8004/2", bus.collision_o, bus.overlap_cnt_o);
        end
        repeat (2) step(1'b1, 1'b0, 5'd0, 1'b0, put('0, 3, 4'h9), 4'h2);
        step(1'b0, 1'b1, 5'd0, 1'b0, '0, 4'h0);
        tests++;
        if (bus.collision_o !== 16'h0 || bus.overlap_cnt_o !== 16'd0) begin
            failed++;
            $display("[TB] FAIL coll_clear: got %h/%0d expected 0/0", bus.collision_o, bus.overlap_cnt_o);
        end
    endtask

    task automatic test_frame_edge();
        logic [95:0] c;
        c = put(put('0, 3, 4'h9), 16, 4'hA);
        step(1'b0, 1'b1, 5'd0, 1'b0, '0, 4'h0);
        repeat (5) step(1'b1, 1'b0, 5'd0, 1'b0, c, 4'h2);
        step(1'b1, 1'b1, 5'd0, 1'b0, c, 4'h2);
        tests++;
        if (bus.collision_o !== 16'h8004 || bus.overlap_cnt_o !== 16'd5) begin
            failed++;
            $display("[TB] FAIL edge_snapshot: got %h/%0d expected 8004/5", bus.collision_o, bus.overlap_cnt_o);
        end
        tests++;
        if (bus_s.overlap_cnt_o !== 2'd3) begin
            failed++;
            $display("[TB] FAIL edge_saturate: got %0d expected 3", bus_s.overlap_cnt_o);
        end
        step(1'b0, 1'b1, 5'd0, 1'b0, '0, 4'h0);
        tests++;
        if (bus.collision_o !== 16'h8004 || bus.overlap_cnt_o !== 16'd1) begin
            failed++;
            $display("[TB] FAIL edge_new_frame: got %h/%0d expected 8004/1", bus.collision_o, bus.overlap_cnt_o);
        end
        step(1'b0, 1'b1, 5'd0, 1'b0, '0, 4'h0);
        tests++;
        if (bus.collision_o !== 16'h0 || bus.overlap_cnt_o !== 16'd0 || bus_s.overlap_cnt_o !== 2'd0) begin
            failed++;
            $display("[TB] FAIL edge_back_to_back: got %h/%0d/%0d expected 0/0/0",
                     bus.collision_o, bus.overlap_cnt_o, bus_s.overlap_cnt_o);
        end
    endtask

    task automatic test_zorder();
        logic [95:0] c;
        c = put(put('0, 20, 4'h5), 18, 4'h6);
        step(1'b1, 1'b0, 5'd0, 1'b1, c, 4'h3);
        idle();
        tests++;
        if (bus.code_o !== 4'h6) begin
            failed++;
            $display("[TB] FAIL zorder_on: got %h expected 6", bus.code_o);
        end
        step(1'b1, 1'b0, 5'd0, 1'b0, c, 4'h3);
        idle();
        tests++;
        if (bus.code_o !== 4'h3) begin
            failed++;
            $display("[TB] FAIL zorder_off: got %h expected 3", bus.code_o);
        end
        step(1'b1, 1'b0, 5'd29, 1'b1, c, 4'h3);
        idle();
        tests++;
        if (bus.code_o !== 4'h6) begin
            failed++;
            $display("[TB] FAIL select_out_of_range: got %h expected 6", bus.code_o);
        end
        step(1'b1, 1'b0, 5'd20, 1'b0, c, 4'h3);
        idle();
        tests++;
        if (bus.code_o !== 4'h5) begin
            failed++;
            $display("[TB] FAIL select_stick: got %h expected 5", bus.code_o);
        end
    endtask

    task automatic test_random();
        logic [95:0] c;
        logic [15:0] exp_cnt;
        logic [1:0]  exp_cnt_s;
        for (int i = 0; i < 1500; i++) begin
            c = '0;
            for (int k = 1; k <= NS; k++) begin
                if ($urandom_range(0, 5) == 0) c = put(c, k, 4'($urandom_range(1, 15)));
            end
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0),
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), c, 4'($urandom_range(0, 15)));
            exp_cnt   = (pub > 65535) ? 16'hFFFF : 16'(pub);
            exp_cnt_s = (pub > 3) ? 2'd3 : 2'(pub);
            tests++;
            if (bus.code_o !== exp_code || bus.valid_o !== exp_valid) begin
                failed++;
                $display("[TB] FAIL random_code cycle %0d: got %h/%b expected %h/%b",
                         i, bus.code_o, bus.valid_o, exp_code, exp_valid);
            end
            tests++;
            if (bus.collision_o !== exp_coll || bus.overlap_cnt_o !== exp_cnt || bus_s.overlap_cnt_o !== exp_cnt_s) begin
                failed++;
                $display("[TB] FAIL random_frame cycle %0d: got %h/%0d/%0d expected %h/%0d/%0d",
                         i, bus.collision_o, bus.overlap_cnt_o, bus_s.overlap_cnt_o, exp_coll, exp_cnt, exp_cnt_s);
            end
        end
    endtask

    initial begin
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        prio_mode   = 1'b0;
        sel         = '0;
        codes       = '0;
        bg          = '0;
        model_reset();
        #17;
        Reset_n = 1'b1;
        test_reset();
        test_select();
        test_overlap();
        test_collision_priority();
        test_frame_edge();
        test_zorder();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
